// File: rtl/rr_out_port_scheduler.sv
// rr_out_port_scheduler: switch-allocation scheduler for one output port of a 5-port mesh router.
// Round-robin arbitration among input buffers whose head flit targets this port. The wormhole
// lock is held from grant until the tail flit or an abort. Credits track free downstream slots.
// Optional feature: define SA_LOCK_TIMEOUT_EN to force-release a lock that has been stalled for
// LOCK_TIMEOUT cycles. With the macro undefined there is no idle counter and timeout_err is 0.
module rr_out_port_scheduler #(
  parameter int unsigned PORT_ADDRESS = 0,
  parameter int unsigned NUM_INPUTS   = 5,
  parameter int unsigned CREDITS      = 4,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_INPUTS-1:0]        req,
  input  logic [3*NUM_INPUTS-1:0]      dport,
  input  logic [NUM_INPUTS-1:0]        in_valid,
  input  logic [NUM_INPUTS-1:0]        in_tail,
  input  logic                         credit_ret,
  output logic [NUM_INPUTS-1:0]        grant,
  output logic [2:0]                   sel,
  output logic                         fire,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                         timeout_err
);

  localparam int unsigned CntW = $clog2(CREDITS + 1);
  localparam logic [2:0] SelIdle = 3'b111;
  localparam logic [CntW-1:0] CreditMax = CntW'(CREDITS);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [2:0]            sel_q, sel_d;
  logic [2:0]            rr_q, rr_d;
  logic [CntW-1:0]       credit_q, credit_d;

  logic [NUM_INPUTS-1:0] eligible;
  logic                  win_found;
  logic [2:0]            win_idx;
  logic                  sel_req, sel_valid, sel_tail;
  logic                  release_lock;

`ifdef SA_LOCK_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(LOCK_TIMEOUT - 1);
  logic [IdleW-1:0] idle_q, idle_d;
  logic             tout_q, tout_d;
`endif

  // Wrap-around increment of an input index.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'(NUM_INPUTS - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // An input is eligible when it holds a head whose destination is this port.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible[i] = req[i] && (dport[3*i +: 3] == 3'(PORT_ADDRESS));
    end
  end

  // Round-robin winner: first eligible index scanning upward from rr_q.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = (int'(rr_q) + k) % NUM_INPUTS;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(idx);
      end
    end
  end

  // Mux the locked input's status via the one-hot grant (no out-of-range index when idle).
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_tail  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q[i]) begin
        sel_req   = req[i];
        sel_valid = in_valid[i];
        sel_tail  = in_tail[i];
      end
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      sel_q    <= SelIdle;
      rr_q     <= '0;
      credit_q <= CreditMax;
`ifdef SA_LOCK_TIMEOUT_EN
      idle_q   <= '0;
      tout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
`ifdef SA_LOCK_TIMEOUT_EN
      idle_q   <= idle_d;
      tout_q   <= tout_d;
`endif
    end
  end

  // Next-state logic: grant on a winner, release on tail fire, abort or (optionally) timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    release_lock = 1'b0;
`ifdef SA_LOCK_TIMEOUT_EN
    idle_d       = idle_q;
    tout_d       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef SA_LOCK_TIMEOUT_EN
        idle_d = '0;
`endif
        if (win_found) begin
          state_d          = StLocked;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sel_d            = win_idx;
          rr_d             = next_idx(win_idx);
        end
      end
      StLocked: begin
        // Abort wins over fire: a dropped request releases without a transfer.
        if (!sel_req || (fire && sel_tail)) begin
          release_lock = 1'b1;
`ifdef SA_LOCK_TIMEOUT_EN
        end else if (fire) begin
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          release_lock = 1'b1;
          tout_d       = 1'b1;
          rr_d         = next_idx(sel_q);
        end else begin
          idle_d = idle_q + IdleW'(1);
`endif
        end
        if (release_lock) begin
          state_d = StIdle;
          grant_d = '0;
          sel_d   = SelIdle;
`ifdef SA_LOCK_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        sel_d   = SelIdle;
      end
    endcase
  end

  // Credit counter: -1 per fire, +1 per return, saturating at CREDITS.
  always_comb begin
    credit_d = credit_q;
    if (fire && !credit_ret) begin
      credit_d = credit_q - CntW'(1);
    end else if (credit_ret && !fire && (credit_q != CreditMax)) begin
      credit_d = credit_q + CntW'(1);
    end
  end

  // Outputs: fire is combinational on the locked input's valid and available credit.
  always_comb begin
    fire       = (state_q == StLocked) && sel_req && sel_valid && (credit_q != '0);
    grant      = grant_q;
    sel        = sel_q;
    credit_cnt = credit_q;
`ifdef SA_LOCK_TIMEOUT_EN
    timeout_err = tout_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_out_port_scheduler.sv
// Testbench for rr_out_port_scheduler: directed scenarios followed by random traffic, all checked
// cycle-by-cycle against a behavioural model (lock owner, round-robin pointer, credit count).
// Honours SA_LOCK_TIMEOUT_EN the same way the design does.
module tb_rr_out_port_scheduler;

  localparam int unsigned N  = 5;
  localparam int unsigned C  = 4;
  localparam int unsigned PA = 0;
  localparam int unsigned LT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, in_valid, in_tail;
  logic [3*N-1:0] dport;
  logic           credit_ret;
  logic [N-1:0]   grant;
  logic [2:0]     sel;
  logic           fire;
  logic [2:0]     credit_cnt;
  logic           timeout_err;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_owner = -1;
  int m_rr    = 0;
  int m_cred  = C;
  int m_idle  = 0;
  int m_ovf   = 0;
  bit m_tout  = 1'b0;

  int fire_seen = 0;
  int tout_seen = 0;
  int ovf_seen  = 0;
  int base;

  rr_out_port_scheduler #(
    .PORT_ADDRESS(PA),
    .NUM_INPUTS  (N),
    .CREDITS     (C),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .dport      (dport),
    .in_valid   (in_valid),
    .in_tail    (in_tail),
    .credit_ret (credit_ret),
    .grant      (grant),
    .sel        (sel),
    .fire       (fire),
    .credit_cnt (credit_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Flags a credit return that arrives with the counter already full.
  always @(posedge clk) begin
    if (!rst && credit_ret && !fire && credit_cnt == 3'(C)) begin
      ovf_seen <= ovf_seen + 1;
      $display("[TB] note: credit return at full credit ignored (t=%0t)", $time);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_dp(input int i, input logic [2:0] v);
    dport[3*i +: 3] = v;
  endtask

  // Advance the model across one clock edge given the inputs held during the cycle.
  task automatic model_step(input bit efire);
    if (rst) begin
      m_owner = -1; m_rr = 0; m_cred = C; m_idle = 0; m_tout = 1'b0;
      return;
    end
    m_tout = 1'b0;
    if (efire && !credit_ret) m_cred--;
    else if (credit_ret && !efire) begin
      if (m_cred < C) m_cred++;
      else m_ovf++;
    end
    if (m_owner < 0) begin
      m_idle = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (req[i] && dport[3*i +: 3] == 3'(PA)) begin
          m_owner = i;
          m_rr    = (i + 1) % N;
          break;
        end
      end
    end else if (!req[m_owner] || (efire && in_tail[m_owner])) begin
      m_owner = -1;
      m_idle  = 0;
    end else begin
`ifdef SA_LOCK_TIMEOUT_EN
      if (efire) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= LT) begin
          m_tout  = 1'b1;
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
          m_idle  = 0;
        end
      end
`endif
    end
  endtask

  // One clock cycle: check fire before the edge, registered outputs after it.
  task automatic cycle();
    bit efire;
    #3;
    efire = !rst && (m_owner >= 0) && req[m_owner] && in_valid[m_owner] && (m_cred > 0);
    if (!rst) chk("fire", 32'(fire), 32'(efire));
    if (fire === 1'b1) fire_seen++;
    @(posedge clk);
    #1;
    model_step(efire);
    if (timeout_err === 1'b1) tout_seen++;
    chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("sel", 32'(sel), (m_owner < 0) ? 32'd7 : 32'(m_owner));
    chk("credit_cnt", 32'(credit_cnt), 32'(m_cred));
    chk("timeout_err", 32'(timeout_err), 32'(m_tout));
  endtask

  initial begin
    rst = 1'b1; req = '0; in_valid = '0; in_tail = '0; dport = '0; credit_ret = 1'b0;

    // Reset state.
    cycle();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd7);
    chk("rst_credit", 32'(credit_cnt), 32'd4);
    chk("rst_tout", 32'(timeout_err), 32'd0);

    // Round-robin between inputs 1 and 3, bubble on release, re-request waits for tail.
    req = 5'b01010;
    cycle();
    chk("rr_first", 32'(grant), 32'h02);
    in_valid = 5'b00010; in_tail = 5'b00010;
    cycle();
    chk("rr_release", 32'(grant), 32'h00);
    req = 5'b01000; in_valid = '0; in_tail = '0;
    cycle();
    chk("rr_second", 32'(grant), 32'h08);
    req = 5'b01010; in_valid = 5'b01000;
    cycle();
    chk("rr_held", 32'(grant), 32'h08);
    in_tail = 5'b01000;
    cycle();
    chk("rr_tail3", 32'(grant), 32'h00);
    req = 5'b00010; in_valid = '0; in_tail = '0;
    cycle();
    chk("rr_regrant1", 32'(grant), 32'h02);
    req = '0; credit_ret = 1'b1;
    repeat (3) cycle();
    credit_ret = 1'b0;

    // Long packet drains credits then stalls; one return allows exactly one more flit.
    req = 5'b00100;
    cycle();
    in_valid = 5'b00100;
    base = fire_seen;
    repeat (6) cycle();
    chk("stall_fires", 32'(fire_seen - base), 32'd4);
    chk("stall_credit", 32'(credit_cnt), 32'd0);
    credit_ret = 1'b1;
    cycle();
    credit_ret = 1'b0;
    repeat (3) cycle();
    chk("one_more_fire", 32'(fire_seen - base), 32'd5);
    chk("still_locked", 32'(grant), 32'h04);
    req = '0;
    cycle();
    chk("abort_grant", 32'(grant), 32'h00);
    in_valid = '0; credit_ret = 1'b1;
    repeat (4) cycle();
    credit_ret = 1'b0;

    // Simultaneous fire and return, then return at full credit.
    req = 5'b00001;
    cycle();
    in_valid = 5'b00001;
    repeat (2) cycle();
    credit_ret = 1'b1;
    cycle();
    chk("fire_and_ret", 32'(credit_cnt), 32'd2);
    req = '0; in_valid = '0; credit_ret = 1'b0;
    cycle();
    credit_ret = 1'b1;
    repeat (3) cycle();
    chk("ret_saturate", 32'(credit_cnt), 32'd4);
    credit_ret = 1'b0;

    // Request for another port is never granted; dport not re-checked once locked.
    req = 5'b00100; set_dp(2, 3'd3);
    repeat (10) cycle();
    chk("other_port", 32'(grant), 32'h00);
    set_dp(2, 3'd0);
    cycle();
    set_dp(2, 3'd3);
    cycle();
    chk("dport_not_rechecked", 32'(grant), 32'h04);
    in_valid = 5'b00100;
    cycle();
    req = '0;
    cycle();
    chk("drop_mid_packet", 32'(grant), 32'h00);
    set_dp(2, 3'd0); in_valid = '0; credit_ret = 1'b1;
    cycle();
    credit_ret = 1'b0;

    // Locked with no valid data for 100 cycles.
    req = 5'b10000;
    cycle();
    base = tout_seen;
    repeat (100) cycle();
`ifdef SA_LOCK_TIMEOUT_EN
    chk("timeout_pulsed", 32'(tout_seen > base), 32'd1);
`else
    chk("lock_held", 32'(grant), 32'h10);
    chk("no_timeout", 32'(tout_seen - base), 32'd0);
`endif
    req = '0;
    cycle();

    // Reset in the middle of a packet.
    req = 5'b00010;
    cycle();
    in_valid = 5'b00010;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = '0; in_valid = '0;
    cycle();
    chk("midrst_grant", 32'(grant), 32'h00);
    chk("midrst_credit", 32'(credit_cnt), 32'd4);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      req      = N'($urandom);
      in_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        in_tail[i] = ($urandom_range(0, 3) == 0);
        set_dp(i, ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 4)) : 3'd0);
      end
      credit_ret = ($urandom_range(0, 2) == 0);
      cycle();
    end
    req = '0; in_valid = '0; in_tail = '0; credit_ret = 1'b0;
    cycle();
    chk("ovf_events", 32'(ovf_seen), 32'(m_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
